multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 op  input  7  Instr[6:0]; funct3  input  3  Instr[14:12]; funct7b5  input  1  Instr[30]; zero  input  1  ALU zero flag.
REQ-005 pc_write  output  1  PC load enable (pc_update OR taken branch).
REQ-006 adr_src  output  1  memory address mux: 0=PC, 1=ALUOut.
REQ-007 mem_write  output  1; ir_write  output  1; reg_write  output  1: write strobes.
REQ-008 result_src  output  2  00=ALUOut, 01=mem data, 10=ALU result.
REQ-009 alu_src_a  output  2  00=PC, 01=OldPC, 10=rs1 data, 11=zero; alu_src_b  output  2  00=rs2 data, 01=ImmExt, 10=constant 4.
REQ-010 alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-011 imm_src  output  3  immediate-extender select: 000 I, 001 S, 010 B, 011 U, 100 J.
REQ-012 illegal  output  1  unsupported-opcode trap flag.

Function
REQ-013 Moore FSM, one-hot or binary (implementer's choice), states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, LUI, TRAP; state register updates on rising clk only.
REQ-014 Outputs not listed for a state SHALL be 0 in that state; all outputs are combinational from state (plus op/funct/zero where stated).
REQ-015 FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, add, result_src=10, pc_update=1; -> DECODE.
REQ-016 DECODE: alu_src_a=01, alu_src_b=01, add; next by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ, 1101111 -> JAL, 0110111 -> LUI, other -> per REQ-028.
REQ-017 MEMADR: alu_src_a=10, alu_src_b=01, add; op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
REQ-018 MEMREAD: result_src=00, adr_src=1; -> MEMWB. MEMWB: result_src=01, reg_write=1; -> FETCH.
REQ-019 MEMWRITE: result_src=00, adr_src=1, mem_write=1; -> FETCH.
REQ-020 EXECR: alu_src_a=10, alu_src_b=00, ALU decode; EXECI: alu_src_a=10, alu_src_b=01, ALU decode; both -> ALUWB. ALUWB: result_src=00, reg_write=1; -> FETCH.
REQ-021 ALU decode by funct3: 000 -> sub if op[5]&funct7b5 else add; 010 -> slt; 110 -> or; 111 -> and; others -> add.
REQ-022 BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00; pc_write=zero when funct3=000, else 0; -> FETCH.
REQ-023 JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_update=1; -> ALUWB. LUI: alu_src_a=11, alu_src_b=01, add; -> ALUWB.
REQ-024 imm_src is a function of op in every state: 0100011->001, 1100011->010, 0110111->011, 1101111->100, else 000.
REQ-025 Instruction latencies (cycles, FETCH to next FETCH): lw 5, sw 4, R/I-ALU 4, beq 3, jal 4, lui 4.

Reset
REQ-026 rst_n low SHALL force state to FETCH immediately, independent of clk; while low, pc_write, ir_write, mem_write, reg_write SHALL be 0 and illegal SHALL be 0.
REQ-027 After rst_n deassertion, the first rising edge SHALL complete a FETCH; reset mid-instruction abandons it with no further write strobes.

Configuration
REQ-028 Macro ILLEGAL_TRAP_EN defined: unrecognized op in DECODE -> TRAP; TRAP holds until reset with illegal=1 and all strobes 0. Undefined: unrecognized op -> FETCH (treated as NOP, 2 cycles); TRAP absent; illegal tied 0.

Verification
REQ-029 Reset then op=0000011 (lw): states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 with result_src=01 only in cycle 5; imm_src=000.
REQ-030 op=0110011, funct3=000, funct7b5=1 -> alu_control=001 in EXECR, reg_write=1 in ALUWB; funct7b5=0 -> 000.
REQ-031 op=1100011, funct3=000: zero=1 -> pc_write=1 in BEQ cycle; zero=0 -> pc_write=0; imm_src=010 throughout.
REQ-032 op=0100011 -> mem_write=1 exactly one cycle (4th), adr_src=1, reg_write never asserted, imm_src=001.
REQ-033 op=1111111: with ILLEGAL_TRAP_EN, illegal=1 from cycle 3 and held 10+ cycles until rst_n low; without, returns to FETCH in cycle 3, illegal=0.
REQ-034 rst_n pulsed low mid-MEMWB: reg_write drops to 0 asynchronously, state FETCH on release.

Source files
------------

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_controller_if: decode inputs and control outputs of the multicycle controller. Rev 1.0
// ---------------------------------------------------------------------------
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [2:0] imm_src;
  logic       illegal;

  // Datapath side: supplies instruction fields and the zero flag.
  modport master (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
    input  result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal
  );

  modport slave (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
    output result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_controller: Moore control FSM for a multicycle RV32I subset; ILLEGAL_TRAP_EN adds a TRAP state. Rev 1.0
// ---------------------------------------------------------------------------
module multicycle_controller (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.slave  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
`ifdef ILLEGAL_TRAP_EN
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
`else
    S_LUI      = 4'd11
`endif
  } state_t;

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_rtype = 7'b0110011;
  localparam logic [6:0] c_op_itype = 7'b0010011;
  localparam logic [6:0] c_op_beq   = 7'b1100011;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_lui   = 7'b0110111;

  state_t state_q;
  state_t state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          c_op_load, c_op_store: state_d = S_MEMADR;
          c_op_rtype:            state_d = S_EXECR;
          c_op_itype:            state_d = S_EXECI;
          c_op_beq:              state_d = S_BEQ;
          c_op_jal:              state_d = S_JAL;
          c_op_lui:              state_d = S_LUI;
`ifdef ILLEGAL_TRAP_EN
          default:               state_d = S_TRAP;
`else
          default:               state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  logic [2:0] alu_dec;
  always_comb begin
    alu_dec = 3'b000;
    case (bus.funct3)
      3'b000:  alu_dec = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  end

  always_comb begin
    case (bus.op)
      c_op_store: bus.imm_src = 3'b001;
      c_op_beq:   bus.imm_src = 3'b010;
      c_op_lui:   bus.imm_src = 3'b011;
      c_op_jal:   bus.imm_src = 3'b100;
      default:    bus.imm_src = 3'b000;
    endcase
  end

  logic pc_update;
  logic branch_taken;
  logic mem_write_s;
  logic ir_write_s;
  logic reg_write_s;
  logic illegal_s;

  always_comb begin
    pc_update       = 1'b0;
    branch_taken    = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_write_s     = 1'b0;
    illegal_s       = 1'b0;
    bus.adr_src     = 1'b0;
    bus.result_src  = 2'b00;
    bus.alu_src_a   = 2'b00;
    bus.alu_src_b   = 2'b00;
    bus.alu_control = 3'b000;
    case (state_q)
      S_FETCH: begin
        ir_write_s     = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        pc_update      = 1'b1;
      end
      S_DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      S_MEMREAD: bus.adr_src = 1'b1;
      S_MEMWB: begin
        bus.result_src = 2'b01;
        reg_write_s    = 1'b1;
      end
      S_MEMWRITE: begin
        bus.adr_src = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_control = alu_dec;
      end
      S_EXECI: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_src_b   = 2'b01;
        bus.alu_control = alu_dec;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_BEQ: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_control = 3'b001;
        branch_taken    = bus.zero & (bus.funct3 == 3'b000);
      end
      S_JAL: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        pc_update     = 1'b1;
      end
      S_LUI: begin
        bus.alu_src_a = 2'b11;
        bus.alu_src_b = 2'b01;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: illegal_s = 1'b1;
`endif
      default: ;
    endcase
  end

  // Strobes are masked by rst_n so they drop the instant reset asserts.
  assign bus.pc_write  = rst_n & (pc_update | branch_taken);
  assign bus.mem_write = rst_n & mem_write_s;
  assign bus.ir_write  = rst_n & ir_write_s;
  assign bus.reg_write = rst_n & reg_write_s;
  assign bus.illegal   = rst_n & illegal_s;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_controller: scoreboard bench comparing per-cycle control vectors. Rev 1.0
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  logic clk;
  logic rst_n;
  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {F, D, MA, MR, MWB, MWR, XR, XI, AW, BQ, JL, LU, TR, RST} st_e;

  int vectors    = 0;
  int miscompares = 0;
  logic [17:0] sb_q[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;
  logic       cur_z;

  // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal}
  function automatic logic [17:0] exp_vec(st_e st, logic [6:0] op, logic [2:0] f3, logic f7, logic z);
    logic pcw = 1'b0, adr = 1'b0, mw = 1'b0, ir = 1'b0, rw = 1'b0, ill = 1'b0;
    logic [1:0] res = 2'b00, a = 2'b00, b = 2'b00;
    logic [2:0] alu = 3'b000, dec, imm;
    case (f3)
      3'b000:  dec = (op[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  dec = 3'b101;
      3'b110:  dec = 3'b011;
      3'b111:  dec = 3'b010;
      default: dec = 3'b000;
    endcase
    if (op == 7'b0100011)      imm = 3'b001;
    else if (op == 7'b1100011) imm = 3'b010;
    else if (op == 7'b0110111) imm = 3'b011;
    else if (op == 7'b1101111) imm = 3'b100;
    else                       imm = 3'b000;
    case (st)
      F:   begin ir = 1'b1; b = 2'b10; res = 2'b10; pcw = 1'b1; end
      RST: begin b = 2'b10; res = 2'b10; end
      D:   begin a = 2'b01; b = 2'b01; end
      MA:  begin a = 2'b10; b = 2'b01; end
      MR:  adr = 1'b1;
      MWB: begin res = 2'b01; rw = 1'b1; end
      MWR: begin adr = 1'b1; mw = 1'b1; end
      XR:  begin a = 2'b10; alu = dec; end
      XI:  begin a = 2'b10; b = 2'b01; alu = dec; end
      AW:  rw = 1'b1;
      BQ:  begin a = 2'b10; alu = 3'b001; pcw = (f3 == 3'b000) && z; end
      JL:  begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      LU:  begin a = 2'b11; b = 2'b01; end
      TR:  ill = 1'b1;
      default: ;
    endcase
    return {pcw, adr, mw, ir, rw, res, a, b, alu, imm, ill};
  endfunction

  function automatic logic [17:0] obs();
    return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
            bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.imm_src, bus.illegal};
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z;
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
  endtask

  task automatic push(input st_e st);
    sb_q.push_back(exp_vec(st, cur_op, cur_f3, cur_f7, cur_z));
  endtask

  task automatic test_reset();
    logic [17:0] e;
    drive(7'b0000000, 3'b000, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    e = exp_vec(RST, cur_op, cur_f3, cur_f7, cur_z); vectors++;
    if (obs() !== e) begin miscompares++; $display("FAIL reset_t0: got %05h expected %05h", obs(), e); end
    @(negedge clk); #1;
    vectors++;
    if (obs() !== e) begin miscompares++; $display("FAIL reset_held: got %05h expected %05h", obs(), e); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_store();
    logic [17:0] e;
    for (int k = 0; k < 2; k++) begin
      int n = 0;
      if (k == 0) begin
        drive(7'b0000011, 3'b010, 1'b0, 1'($urandom_range(0, 1)));
        push(F); push(D); push(MA); push(MR); push(MWB);
      end else begin
        drive(7'b0100011, 3'b010, 1'b0, 1'($urandom_range(0, 1)));
        push(F); push(D); push(MA); push(MWR);
      end
      while (sb_q.size() != 0) begin
        #1; e = sb_q.pop_front(); vectors++;
        if (obs() !== e) begin
          miscompares++;
          $display("FAIL ldst k%0d cyc%0d: got %05h expected %05h", k, n, obs(), e);
        end
        n++; @(negedge clk);
      end
    end
  endtask

  task automatic test_alu();
    logic [17:0] e;
    logic [10:0] tbl [8];
    tbl = '{{7'b0110011, 3'b000, 1'b0}, {7'b0110011, 3'b000, 1'b1},
            {7'b0110011, 3'b010, 1'b0}, {7'b0110011, 3'b110, 1'b1},
            {7'b0110011, 3'b111, 1'b0}, {7'b0110011, 3'b001, 1'b1},
            {7'b0010011, 3'b000, 1'b1}, {7'b0010011, 3'b110, 1'b0}};
    for (int k = 0; k < 8; k++) begin
      int n = 0;
      logic [10:0] t;
      t = tbl[k];
      drive(t[10:4], t[3:1], t[0], 1'($urandom_range(0, 1)));
      push(F); push(D);
      if (t[10:4] == 7'b0110011) push(XR); else push(XI);
      push(AW);
      while (sb_q.size() != 0) begin
        #1; e = sb_q.pop_front(); vectors++;
        if (obs() !== e) begin
          miscompares++;
          $display("FAIL alu k%0d cyc%0d: got %05h expected %05h", k, n, obs(), e);
        end
        n++; @(negedge clk);
      end
    end
  endtask

  task automatic test_branch();
    logic [17:0] e;
    logic [3:0] tbl [4];
    tbl = '{{3'b000, 1'b1}, {3'b000, 1'b0}, {3'b001, 1'b1}, {3'b000, 1'b1}};
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      logic [3:0] t;
      t = tbl[k];
      drive(7'b1100011, t[3:1], 1'b0, t[0]);
      push(F); push(D); push(BQ);
      while (sb_q.size() != 0) begin
        #1; e = sb_q.pop_front(); vectors++;
        if (obs() !== e) begin
          miscompares++;
          $display("FAIL beq k%0d cyc%0d: got %05h expected %05h", k, n, obs(), e);
        end
        n++; @(negedge clk);
      end
    end
  endtask

  task automatic test_jump_lui();
    logic [17:0] e;
    for (int k = 0; k < 2; k++) begin
      int n = 0;
      if (k == 0) begin
        drive(7'b1101111, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
        push(F); push(D); push(JL); push(AW);
      end else begin
        drive(7'b0110111, 3'($urandom_range(0, 7)), 1'b1, 1'b1);
        push(F); push(D); push(LU); push(AW);
      end
      while (sb_q.size() != 0) begin
        #1; e = sb_q.pop_front(); vectors++;
        if (obs() !== e) begin
          miscompares++;
          $display("FAIL jal_lui k%0d cyc%0d: got %05h expected %05h", k, n, obs(), e);
        end
        n++; @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid_memwb();
    logic [17:0] e;
    int n = 0;
    drive(7'b0000011, 3'b010, 1'b0, 1'b0);
    push(F); push(D); push(MA); push(MR);
    while (sb_q.size() != 0) begin
      #1; e = sb_q.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL midwb_pre cyc%0d: got %05h expected %05h", n, obs(), e);
      end
      n++; @(negedge clk);
    end
    #1;
    e = exp_vec(MWB, cur_op, cur_f3, cur_f7, cur_z); vectors++;
    if (obs() !== e) begin miscompares++; $display("FAIL midwb_state: got %05h expected %05h", obs(), e); end
    rst_n = 1'b0;
    #1;
    e = exp_vec(RST, cur_op, cur_f3, cur_f7, cur_z); vectors++;
    if (obs() !== e) begin miscompares++; $display("FAIL midwb_async: got %05h expected %05h", obs(), e); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    push(F); push(D); push(MA); push(MR); push(MWB);
    while (sb_q.size() != 0) begin
      #1; e = sb_q.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL midwb_post cyc%0d: got %05h expected %05h", n, obs(), e);
      end
      n++; @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [17:0] e;
    int n = 0;
    drive(7'b1111111, 3'b000, 1'b0, 1'b1);
    push(F); push(D);
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 12; k++) push(TR);
`else
    push(F);
`endif
    while (sb_q.size() != 0) begin
      #1; e = sb_q.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL illegal cyc%0d: got %05h expected %05h", n, obs(), e);
      end
      n++; @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    e = exp_vec(RST, cur_op, cur_f3, cur_f7, cur_z); vectors++;
    if (obs() !== e) begin miscompares++; $display("FAIL illegal_reset: got %05h expected %05h", obs(), e); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    drive(7'b0010011, 3'b111, 1'b0, 1'b0);
    push(F); push(D); push(XI); push(AW);
    while (sb_q.size() != 0) begin
      #1; e = sb_q.pop_front(); vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL illegal_recover cyc%0d: got %05h expected %05h", n, obs(), e);
      end
      n++; @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_alu();
    test_branch();
    test_jump_lui();
    test_reset_mid_memwb();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
